io_arbiter: RTL

Shares one half-duplex SPI transaction engine (the byte-sequencing IO module driving the SPI master) between NUM_REQ requesters.
- Arbitration is round-robin.
- Each requester supplies its own TX/RX byte counts and TX bytes by index.
- The arbiter fires the engine's active-low send strobe, steers TX bytes and received-byte writes to and from the granted requester, and reports completion or timeout.
- Sits between CPU-side IO peripherals (flash, sensor bridges) and the shared IO engine.

---
 rtl/io_arb_pkg.sv | 22 ++
 rtl/io_arbiter_if.sv | 46 ++++
 rtl/rr_picker.sv | 32 +++
 rtl/io_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/io_arb_pkg.sv
// Shared types and helpers for the SPI IO-engine arbiter.
package io_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StBusy,
        StDone
    } arb_state_e;

    localparam int unsigned DefCntW = 4;
    localparam int unsigned MaxReq  = 8;

    // Extract byte number idx from a packed vector of up to MaxReq bytes.
    function automatic logic [7:0] byte_slice(input logic [8*MaxReq-1:0] vec,
                                              input int unsigned         idx);
        logic [8*MaxReq-1:0] shifted;
        shifted = vec >> (idx * 8);
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/io_arbiter_if.sv
// Requester-side and engine-side signals of the IO arbiter, bundled as one interface.
interface io_arbiter_if
    import io_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = DefCntW
) ();

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_tx_cnt;
    logic [NUM_REQ*CNT_W-1:0] req_rx_cnt;
    logic [NUM_REQ*8-1:0]     req_tx_data;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     err;
    logic [CNT_W-1:0]         tx_index;
    logic [CNT_W-1:0]         rx_index;
    logic [7:0]               rx_data;
    logic [NUM_REQ-1:0]       rx_wr;
    logic                     io_send;
    logic [CNT_W-1:0]         io_tx_cnt;
    logic [CNT_W-1:0]         io_rx_cnt;
    logic [7:0]               io_byte_to_send;
    logic [CNT_W-1:0]         io_tx_index;
    logic [CNT_W-1:0]         io_rx_index;
    logic [7:0]               io_byte_received;
    logic                     io_wr_byte;
    logic                     io_done;

    // Arbiter side.
    modport master (
        input  req, req_tx_cnt, req_rx_cnt, req_tx_data,
        input  io_tx_index, io_rx_index, io_byte_received, io_wr_byte, io_done,
        output grant, done, err, tx_index, rx_index, rx_data, rx_wr,
        output io_send, io_tx_cnt, io_rx_cnt, io_byte_to_send
    );

    // Requesters plus engine.
    modport slave (
        output req, req_tx_cnt, req_rx_cnt, req_tx_data,
        output io_tx_index, io_rx_index, io_byte_received, io_wr_byte, io_done,
        input  grant, done, err, tx_index, rx_index, rx_data, rx_wr,
        input  io_send, io_tx_cnt, io_rx_cnt, io_byte_to_send
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PtrW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PtrW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PtrW-1:0]    idx_o,
    output logic               valid_o
);

    logic            found;
    logic [PtrW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PtrW'((32'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing one half-duplex SPI transaction engine among NUM_REQ requesters.
module io_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = DefCntW,
    parameter int unsigned TIMEOUT = 4096
) (
    input logic          sysClk,
    input logic          reset,
    io_arbiter_if.master bus
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);
    localparam int unsigned WdW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Timeout fires in the BUSY cycle where the count of elapsed BUSY cycles reaches TIMEOUT.
    localparam logic [WdW-1:0] WdLimit = (TIMEOUT > 0) ? WdW'(TIMEOUT - 1) : '0;

    arb_state_e         state_q;
    logic [PtrW-1:0]    owner_q;
    logic [PtrW-1:0]    ptr_q;
    logic [WdW-1:0]     wdog_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               err_q;
    logic               io_send_q;
    logic [CNT_W-1:0]   tx_cnt_q;
    logic [CNT_W-1:0]   rx_cnt_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [PtrW-1:0]    pick_idx;
    logic               pick_valid;
    logic [CNT_W-1:0]   pick_tx_cnt;
    logic [CNT_W-1:0]   pick_rx_cnt;
    logic [PtrW-1:0]    ptr_next;
    logic [WdW-1:0]     wdog_inc;
    logic               timeout_hit;
    logic               active;
    logic [8*MaxReq-1:0] tx_data_ext;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PtrW    (PtrW)
    ) u_rr_picker (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign pick_tx_cnt = bus.req_tx_cnt[pick_idx*CNT_W +: CNT_W];
    assign pick_rx_cnt = bus.req_rx_cnt[pick_idx*CNT_W +: CNT_W];
    assign ptr_next    = (pick_idx == PtrW'(NUM_REQ - 1)) ? '0 : pick_idx + PtrW'(1);
    assign wdog_inc    = (&wdog_q) ? wdog_q : wdog_q + WdW'(1);
    assign timeout_hit = (TIMEOUT > 0) && (wdog_q >= WdLimit);

    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_q   <= '0;
            ptr_q     <= '0;
            wdog_q    <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            io_send_q <= 1'b1;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
        end else begin
            done_q    <= '0;
            err_q     <= 1'b0;
            io_send_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        owner_q  <= pick_idx;
                        ptr_q    <= ptr_next;
                        tx_cnt_q <= pick_tx_cnt;
                        rx_cnt_q <= pick_rx_cnt;
                        grant_q  <= pick_gnt;
                        if ((pick_tx_cnt == '0) && (pick_rx_cnt == '0)) begin
                            // Nothing to move: skip the engine and complete directly.
                            state_q <= StDone;
                            done_q  <= pick_gnt;
                        end else begin
                            state_q   <= StSend;
                            io_send_q <= 1'b0;
                        end
                    end
                end
                StSend: begin
                    wdog_q  <= '0;
                    state_q <= StBusy;
                end
                StBusy: begin
                    if (bus.io_done) begin
                        state_q <= StDone;
                        done_q  <= grant_q;
                    end else if (timeout_hit) begin
                        state_q <= StDone;
                        done_q  <= grant_q;
                        err_q   <= 1'b1;
                    end else begin
                        wdog_q <= wdog_inc;
                    end
                end
                StDone: begin
                    grant_q <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign active      = (state_q == StSend) || (state_q == StBusy);
    assign tx_data_ext = (8 * MaxReq)'(bus.req_tx_data);

    always_comb begin
        bus.io_byte_to_send = '0;
        bus.tx_index        = '0;
        bus.rx_index        = '0;
        bus.rx_data         = '0;
        bus.rx_wr           = '0;
        if (active) begin
            bus.io_byte_to_send = byte_slice(tx_data_ext, 32'(owner_q));
            bus.tx_index        = bus.io_tx_index;
            bus.rx_index        = bus.io_rx_index;
            bus.rx_data         = bus.io_byte_received;
            bus.rx_wr[owner_q]  = ~bus.io_wr_byte;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.io_send   = io_send_q;
    assign bus.io_tx_cnt = tx_cnt_q;
    assign bus.io_rx_cnt = rx_cnt_q;

endmodule
